v_instr_issuer: RTL and testbench

Scalar-side issue block for the vector coprocessor. It accepts structured vector-operation requests from the scalar core and assembles them into 32-bit RVV instruction words: arithmetic (OPV), unit/strided/indexed load and store, and vsetvli. The words are buffered in a small FIFO and driven to the coprocessor's instruction decoder over a valid/ready link. The block keeps a shadow of the selected element width. It uses that shadow to derive the load/store width field, and it rejects operations issued while no valid configuration is in place.

---
 rtl/v_pkg.sv | 54 +++++
 rtl/v_issue_fifo.sv | 56 +++++
 rtl/v_instr_issuer.sv | 98 +++++++++
 tb/tb_v_instr_issuer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/v_pkg.sv
// Shared vector-coprocessor encodings: request kinds, RVV field enums,
// major opcodes and the load/store width mapping from the selected element width.
package v_pkg;

    typedef enum logic [1:0] {
        REQ_ARITH  = 2'd0,
        REQ_LOAD   = 2'd1,
        REQ_STORE  = 2'd2,
        REQ_CONFIG = 2'd3
    } req_kind_e;

    typedef enum logic [1:0] {
        VSEW_8       = 2'b00,
        VSEW_16      = 2'b01,
        VSEW_32      = 2'b10,
        VSEW_INVALID = 2'b11
    } vsew_e;

    typedef enum logic [2:0] {
        OPIVV  = 3'b000,
        OPFVV  = 3'b001,
        OPMVV  = 3'b010,
        OPIVI  = 3'b011,
        OPIVX  = 3'b100,
        OPFVF  = 3'b101,
        OPMVX  = 3'b110,
        OP_SET = 3'b111
    } funct3_e;

    typedef enum logic [1:0] {
        MOP_UNIT_STRIDE   = 2'b00,
        MOP_INDEXED_UNORD = 2'b01,
        MOP_STRIDED       = 2'b10,
        MOP_INDEXED_ORD   = 2'b11
    } mop_e;

    localparam logic [6:0] OPC_RTYPE = 7'b1010111;
    localparam logic [6:0] OPC_LTYPE = 7'b0000111;
    localparam logic [6:0] OPC_STYPE = 7'b0100111;

    localparam logic [2:0] LSW_8  = 3'b000;
    localparam logic [2:0] LSW_16 = 3'b101;
    localparam logic [2:0] LSW_32 = 3'b110;

    // An invalid width never reaches the encoder because such requests are rejected.
    function automatic logic [2:0] lsw_from_vsew(input vsew_e sew);
        case (sew)
            VSEW_16: lsw_from_vsew = LSW_16;
            VSEW_32: lsw_from_vsew = LSW_32;
            default: lsw_from_vsew = LSW_8;
        endcase
    endfunction

endpackage

// File: rtl/v_issue_fifo.sv
// Generic DEPTH x DATA_W circular-buffer FIFO with occupancy count and full/empty flags.
module v_issue_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;

    logic do_push;
    logic do_pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/v_instr_issuer.sv
// Assembles scalar-core vector requests into RVV instruction words, tracks the
// selected element width, and queues the words toward the coprocessor decoder.
module v_instr_issuer
    import v_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_kind,
    input  logic [5:0]       req_funct6,
    input  logic [2:0]       req_funct3,
    input  logic             req_vm,
    input  logic [4:0]       req_vd,
    input  logic [4:0]       req_vs2,
    input  logic [4:0]       req_src1,
    input  logic [1:0]       req_mop,
    input  logic [1:0]       req_vsew,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             err,
    output logic [CNT_W-1:0] issued_cnt
);

    vsew_e       shadow_vsew;
    req_kind_e   kind;
    logic        accept;
    logic        reject;
    logic        push;
    logic        pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [31:0] word;
    logic [31:0] head_word;
    logic [4:0]  ls_vs2;

    assign kind      = req_kind_e'(req_kind);
    assign req_ready = !fifo_full;
    assign accept    = req_valid && req_ready;
    assign reject    = (kind != REQ_CONFIG) &&
                       ((shadow_vsew == VSEW_INVALID) ||
                        ((kind == REQ_ARITH) && (req_funct3 == OP_SET)));
    assign push      = accept && !reject;
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    // Memory is not reset, so the head is masked until something is queued.
    assign out_instr = out_valid ? head_word : 32'h0;
    assign ls_vs2    = (req_mop == MOP_UNIT_STRIDE) ? 5'd0 : req_vs2;

    always_comb begin
        word = 32'h0;
        case (kind)
            REQ_ARITH:
                word = {req_funct6, req_vm, req_vs2, req_src1, req_funct3, req_vd, OPC_RTYPE};
            REQ_LOAD:
                word = {4'b0000, req_mop, req_vm, ls_vs2, req_src1,
                        lsw_from_vsew(shadow_vsew), req_vd, OPC_LTYPE};
            REQ_STORE:
                word = {4'b0000, req_mop, req_vm, ls_vs2, req_src1,
                        lsw_from_vsew(shadow_vsew), req_vd, OPC_STYPE};
            default:
                word = {1'b0, 6'b000000, req_vsew, 3'b000, req_src1, OP_SET, req_vd, OPC_RTYPE};
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            shadow_vsew <= VSEW_INVALID;
            err         <= 1'b0;
            issued_cnt  <= '0;
        end else begin
            err <= accept && reject;
            if (accept && (kind == REQ_CONFIG))
                shadow_vsew <= vsew_e'(req_vsew);
            if (pop)
                issued_cnt <= issued_cnt + 1'b1;
        end
    end

    v_issue_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (32)
    ) u_fifo (
        .clk       (clk),
        .nrst      (nrst),
        .push      (push),
        .push_data (word),
        .pop       (pop),
        .pop_data  (head_word),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_v_instr_issuer.sv
// Directed bench for v_instr_issuer: encodings, width shadow, rejects, FIFO fill/drain and reset flush.
module tb_v_instr_issuer;

    logic        clk = 1'b0;
    logic        nrst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_kind;
    logic [5:0]  req_funct6;
    logic [2:0]  req_funct3;
    logic        req_vm;
    logic [4:0]  req_vd;
    logic [4:0]  req_vs2;
    logic [4:0]  req_src1;
    logic [1:0]  req_mop;
    logic [1:0]  req_vsew;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        err;
    logic [15:0] issued_cnt;

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;

    v_instr_issuer #(
        .DEPTH (4),
        .CNT_W (16)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_kind   (req_kind),
        .req_funct6 (req_funct6),
        .req_funct3 (req_funct3),
        .req_vm     (req_vm),
        .req_vd     (req_vd),
        .req_vs2    (req_vs2),
        .req_src1   (req_src1),
        .req_mop    (req_mop),
        .req_vsew   (req_vsew),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .err        (err),
        .issued_cnt (issued_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = 1'b0;
    endtask

    task automatic arith(input logic [5:0] f6, input logic [2:0] f3, input logic vm,
                         input logic [4:0] vd, input logic [4:0] vs2, input logic [4:0] src1);
        req_valid = 1'b1; req_kind = 2'd0; req_funct6 = f6; req_funct3 = f3;
        req_vm = vm; req_vd = vd; req_vs2 = vs2; req_src1 = src1;
    endtask

    task automatic ldst(input logic is_store, input logic [1:0] mop, input logic vm,
                        input logic [4:0] vd, input logic [4:0] vs2, input logic [4:0] src1);
        req_valid = 1'b1; req_kind = is_store ? 2'd2 : 2'd1; req_mop = mop;
        req_vm = vm; req_vd = vd; req_vs2 = vs2; req_src1 = src1;
    endtask

    task automatic cfg(input logic [1:0] sew, input logic [4:0] src1, input logic [4:0] vd);
        req_valid = 1'b1; req_kind = 2'd3; req_vsew = sew; req_src1 = src1; req_vd = vd;
    endtask

    initial begin
        nrst = 1'b0; req_valid = 1'b0; req_kind = '0; req_funct6 = '0; req_funct3 = '0;
        req_vm = 1'b0; req_vd = '0; req_vs2 = '0; req_src1 = '0; req_mop = '0;
        req_vsew = '0; out_ready = 1'b0;
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_instr", out_instr, 0);
        check("rst_err", err, 0);
        check("rst_cnt", issued_cnt, 0);
        step();
        nrst = 1'b1;

        // No configuration yet: arith is rejected
        arith(6'd0, 3'd0, 1'b1, 5'd3, 5'd2, 5'd1);
        step();
        check("noconf_err", err, 1);
        check("noconf_valid", out_valid, 0);
        idle();
        step();
        check("err_pulse_end", err, 0);
        check("noconf_still_empty", out_valid, 0);

        // e32 config, then vadd while popping
        cfg(2'b10, 5'd10, 5'd5);
        step();
        check("cfg_valid", out_valid, 1);
        check("cfg_e32_word", out_instr, 32'h010572D7);
        check("cfg_no_err", err, 0);
        arith(6'd0, 3'd0, 1'b1, 5'd3, 5'd2, 5'd1);
        out_ready = 1'b1;
        step(); exp_cnt++;
        check("vadd_word", out_instr, 32'h022081D7);
        check("vadd_cnt", issued_cnt, exp_cnt);
        idle();
        step(); exp_cnt++;
        check("drain1_valid", out_valid, 0);
        check("drain1_cnt", issued_cnt, exp_cnt);
        out_ready = 1'b0;

        // Load widths from the shadow
        ldst(1'b0, 2'b00, 1'b1, 5'd4, 5'd0, 5'd11);
        step();
        check("load_e32_word", out_instr, 32'h0205E207);
        out_ready = 1'b1;
        cfg(2'b00, 5'd0, 5'd0);
        step(); exp_cnt++;
        check("cfg_e8_word", out_instr, 32'h00007057);
        check("cfg_e8_cnt", issued_cnt, exp_cnt);
        ldst(1'b0, 2'b00, 1'b1, 5'd4, 5'd0, 5'd11);
        step(); exp_cnt++;
        check("load_e8_word", out_instr, 32'h02058207);
        ldst(1'b1, 2'b10, 1'b0, 5'd8, 5'd6, 5'd7);
        step(); exp_cnt++;
        check("store_strided_word", out_instr, 32'h08638427);
        ldst(1'b1, 2'b00, 1'b1, 5'd2, 5'd31, 5'd1);
        step(); exp_cnt++;
        check("store_unit_vs2_zero", out_instr, 32'h02008127);
        idle();
        step(); exp_cnt++;
        check("drain2_valid", out_valid, 0);
        check("drain2_cnt", issued_cnt, exp_cnt);
        out_ready = 1'b0;

        // Fill to full with out_ready held low; the 5th request must wait
        for (int i = 0; i < 4; i++) begin
            arith(6'd0, 3'd0, 1'b1, 5'(i), 5'd2, 5'd1);
            step();
            check($sformatf("fill_ready_%0d", i), req_ready, (i < 3) ? 1 : 0);
        end
        arith(6'd0, 3'd0, 1'b1, 5'd4, 5'd2, 5'd1);
        step();
        check("full_ready_low", req_ready, 0);
        check("full_head_stable", out_instr, 32'h02208057);
        check("full_no_err", err, 0);
        idle();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("pop_order_%0d", i), out_instr, 32'h02208057 | (32'(i) << 7));
            step(); exp_cnt++;
        end
        check("fill_drained", out_valid, 0);
        check("fill_cnt", issued_cnt, exp_cnt);
        out_ready = 1'b0;

        // OP_SET arith is rejected without touching the queue
        arith(6'd0, 3'd0, 1'b1, 5'd9, 5'd2, 5'd1);
        step();
        arith(6'd0, 3'b111, 1'b1, 5'd3, 5'd2, 5'd1);
        step();
        check("opset_err", err, 1);
        check("opset_head", out_instr, 32'h022084D7);
        check("opset_cnt", issued_cnt, exp_cnt);
        idle();
        out_ready = 1'b1;
        step(); exp_cnt++;
        check("opset_one_entry", out_valid, 0);
        check("opset_cnt_after", issued_cnt, exp_cnt);
        check("opset_err_end", err, 0);
        out_ready = 1'b0;

        // Reset with words queued
        for (int i = 1; i <= 3; i++) begin
            arith(6'd0, 3'd0, 1'b1, 5'(i), 5'd2, 5'd1);
            step();
        end
        idle();
        check("queued_valid", out_valid, 1);
        #2;
        nrst = 1'b0;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_instr", out_instr, 0);
        check("midrst_cnt", issued_cnt, 0);
        check("midrst_ready", req_ready, 1);
        #2;
        nrst = 1'b1;
        arith(6'd0, 3'd0, 1'b1, 5'd3, 5'd2, 5'd1);
        step();
        check("post_rst_err", err, 1);
        check("post_rst_valid", out_valid, 0);
        idle();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1, "timeout");
    end

endmodule
